// File: rtl/embed_onchip_ram_pipe.sv
// embed_onchip_ram_pipe: Avalon-MM on-chip RAM with byte enables,
// 1- or 2-clock read pipeline, clock enable and zero-clear after reset.
//
// Parameters:
//   DATA_W         data width in bits (multiple of 8)
//   ADDR_W         word-address width
//   DEPTH          number of words (DEPTH <= 2**ADDR_W)
//   READ_LATENCY   accepted read to readdatavalid, 1 or 2 enabled clocks
//   CLEAR_ON_RESET 1: zero every word after reset, waitrequest held meanwhile
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   address, byteenable          word address, write byte-lane enables
//   chipselect, read, write      Avalon-MM slave qualifiers
//   writedata                    write data
//   clken                        clock enable, 0 stalls the access path
//   readdata, readdatavalid      read result and its strobe
//   waitrequest                  high while the clear sweep runs
//   oor_err                      sticky out-of-range access flag
//
// Build option: define EMBED_OCRAM_OOR_ERR_EN to build the oor_err
// detector; without it oor_err is tied to 0.

module embed_onchip_ram_pipe #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 12,
   parameter int DEPTH          = 4000,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_W-1:0]     address,
   input  logic [DATA_W/8-1:0]   byteenable,
   input  logic                  chipselect,
   input  logic                  read,
   input  logic                  write,
   input  logic [DATA_W-1:0]     writedata,
   input  logic                  clken,
   output logic [DATA_W-1:0]     readdata,
   output logic                  readdatavalid,
   output logic                  waitrequest,
   output logic                  oor_err
);

   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_C  = IDX_W'(DEPTH - 1);

   typedef enum logic {
      S_CLEAR,
      S_READY
   } state_t;

   state_t            state_q;
   logic              wait_q;
   logic [IDX_W-1:0]  clr_ptr_q;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [IDX_W-1:0]  idx;
   logic              in_range;
   logic              acc;
   logic              rd_acc;
   logic              wr_acc;
   logic [DATA_W-1:0] rd_data_d;

   logic              rdv_q;
   logic [DATA_W-1:0] rdata_q;

   assign idx      = address[IDX_W-1:0];
   assign in_range = ({1'b0, address} < DEPTH_C);

   assign acc    = chipselect & (read | write) & ~wait_q & clken;
   // write has priority over a simultaneous read
   assign wr_acc = acc & write;
   assign rd_acc = acc & read & ~write;

   // out-of-range reads return zero; idx may alias, so mux it away
   assign rd_data_d = in_range ? mem_q[idx] : '0;

   // control FSM: clear sweep ignores clken
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
         wait_q    <= (CLEAR_ON_RESET != 0);
         clr_ptr_q <= '0;
      end else begin
         unique case (state_q)
            S_CLEAR: begin
               if (clr_ptr_q == LAST_C) begin
                  state_q <= S_READY;
                  wait_q  <= 1'b0;
               end else begin
                  clr_ptr_q <= clr_ptr_q + IDX_W'(1);
               end
            end
            S_READY: begin
               wait_q <= 1'b0;
            end
            default: begin
               state_q <= S_READY;
               wait_q  <= 1'b0;
            end
         endcase
      end
   end

   // storage: clear sweep or byte-lane write
   always_ff @(posedge clk) begin
      if (reset_n && (state_q == S_CLEAR)) begin
         mem_q[clr_ptr_q] <= '0;
      end else if (reset_n && wr_acc && in_range) begin
         for (int b = 0; b < NB; b++) begin
            if (byteenable[b]) begin
               mem_q[idx][8*b +: 8] <= writedata[8*b +: 8];
            end
         end
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic              p_vld_q;
         logic [DATA_W-1:0] p_data_q;

         always_ff @(posedge clk) begin
            if (!reset_n) begin
               p_vld_q  <= 1'b0;
               p_data_q <= '0;
               rdv_q    <= 1'b0;
               rdata_q  <= '0;
            end else if (clken) begin
               p_vld_q <= rd_acc;
               if (rd_acc) begin
                  p_data_q <= rd_data_d;
               end
               rdv_q <= p_vld_q;
               if (p_vld_q) begin
                  rdata_q <= p_data_q;
               end
            end
         end
      end else begin : g_lat1
         always_ff @(posedge clk) begin
            if (!reset_n) begin
               rdv_q   <= 1'b0;
               rdata_q <= '0;
            end else if (clken) begin
               rdv_q <= rd_acc;
               if (rd_acc) begin
                  rdata_q <= rd_data_d;
               end
            end
         end
      end
   endgenerate

   assign readdata      = rdata_q;
   // a held result is only presented on an enabled clock
   assign readdatavalid = rdv_q & clken;
   assign waitrequest   = wait_q;

`ifdef EMBED_OCRAM_OOR_ERR_EN
   logic oor_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         oor_q <= 1'b0;
      end else if (acc && !in_range) begin
         oor_q <= 1'b1;
      end
   end

   assign oor_err = oor_q;
`else
   assign oor_err = 1'b0;
`endif

endmodule

// File: tb/tb_embed_onchip_ram_pipe.sv
// Directed bench for embed_onchip_ram_pipe: a latency-1 default
// instance and a small latency-2 instance share the stimulus.

module tb_embed_onchip_ram_pipe;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [11:0] address;
   logic [3:0]  byteenable;
   logic        chipselect;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic        clken;

   logic [31:0] readdata;
   logic        readdatavalid;
   logic        waitrequest;
   logic        oor_err;

   logic [31:0] rd2;
   logic        rdv2;
   logic        wr2;
   logic        oor2;

   int checks = 0;
   int errors = 0;

`ifdef EMBED_OCRAM_OOR_ERR_EN
   localparam logic OOR_EXP = 1'b1;
`else
   localparam logic OOR_EXP = 1'b0;
`endif

   always #5 clk = ~clk;

   embed_onchip_ram_pipe dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .address       (address),
      .byteenable    (byteenable),
      .chipselect    (chipselect),
      .read          (read),
      .write         (write),
      .writedata     (writedata),
      .clken         (clken),
      .readdata      (readdata),
      .readdatavalid (readdatavalid),
      .waitrequest   (waitrequest),
      .oor_err       (oor_err)
   );

   embed_onchip_ram_pipe #(
      .DEPTH        (16),
      .READ_LATENCY (2)
   ) dut2 (
      .clk           (clk),
      .reset_n       (reset_n),
      .address       (address),
      .byteenable    (byteenable),
      .chipselect    (chipselect),
      .read          (read),
      .write         (write),
      .writedata     (writedata),
      .clken         (clken),
      .readdata      (rd2),
      .readdatavalid (rdv2),
      .waitrequest   (wr2),
      .oor_err       (oor2)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      chipselect = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
   endtask

   task automatic do_wr(input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] be);
      chipselect = 1'b1;
      write      = 1'b1;
      read       = 1'b0;
      address    = a;
      writedata  = d;
      byteenable = be;
      cyc();
      idle();
   endtask

   task automatic do_rd(input logic [11:0] a);
      chipselect = 1'b1;
      read       = 1'b1;
      write      = 1'b0;
      address    = a;
      cyc();
      idle();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      clken   = 1'b1;
      idle();
      address    = '0;
      byteenable = '0;
      writedata  = '0;
      repeat (3) cyc();
      checks++;
      if (readdatavalid !== 1'b0 || readdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_out: rdv=%b data=%h want 0/0",
                  readdatavalid, readdata);
      end
      checks++;
      if (waitrequest !== 1'b1 || wr2 !== 1'b1) begin
         errors++;
         $display("FAIL reset_wait: got %b/%b want 1/1", waitrequest, wr2);
      end
      checks++;
      if (oor_err !== 1'b0 || rdv2 !== 1'b0) begin
         errors++;
         $display("FAIL reset_oor: oor=%b rdv2=%b want 0/0", oor_err, rdv2);
      end
   endtask

   task automatic test_clear();
      int n;
      reset_n = 1'b1;
      n = 0;
      while (waitrequest === 1'b1 && n < 5000) begin
         n++;
         cyc();
      end
      checks++;
      if (n != 4000) begin
         errors++;
         $display("FAIL clear_len: got %0d clocks want 4000", n);
      end
      checks++;
      if (wr2 !== 1'b0 || waitrequest !== 1'b0) begin
         errors++;
         $display("FAIL clear_ready: got %b/%b want 0/0", waitrequest, wr2);
      end
      do_rd(12'h005);
      checks++;
      if (readdatavalid !== 1'b1 || readdata !== 32'h0) begin
         errors++;
         $display("FAIL clear_read: rdv=%b data=%h want 1/00000000",
                  readdatavalid, readdata);
      end
   endtask

   task automatic test_byteenable();
      do_wr(12'h010, 32'hDEADBEEF, 4'b1111);
      do_wr(12'h010, 32'h11223344, 4'b0101);
      do_rd(12'h010);
      checks++;
      if (readdatavalid !== 1'b1 || readdata !== 32'hDE22BE44) begin
         errors++;
         $display("FAIL byte_lanes: rdv=%b data=%h want 1/de22be44",
                  readdatavalid, readdata);
      end
      cyc();
      checks++;
      if (readdatavalid !== 1'b0 || readdata !== 32'hDE22BE44) begin
         errors++;
         $display("FAIL data_hold: rdv=%b data=%h want 0/de22be44",
                  readdatavalid, readdata);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] e;
      for (int i = 0; i < 4; i++) begin
         do_wr(12'(i), 32'hA5A50000 + 32'(i), 4'b1111);
      end
      for (int i = 0; i < 4; i++) begin
         chipselect = 1'b1;
         read       = 1'b1;
         address    = 12'(i);
         cyc();
         e = 32'hA5A50000 + 32'(i);
         checks++;
         if (readdatavalid !== 1'b1 || readdata !== e) begin
            errors++;
            $display("FAIL b2b_l1[%0d]: rdv=%b data=%h want 1/%h",
                     i, readdatavalid, readdata, e);
         end
         e = 32'hA5A50000 + 32'(i) - 32'd1;
         checks++;
         if (i == 0) begin
            if (rdv2 !== 1'b0) begin
               errors++;
               $display("FAIL b2b_l2_first: rdv2=%b want 0", rdv2);
            end
         end else if (rdv2 !== 1'b1 || rd2 !== e) begin
            errors++;
            $display("FAIL b2b_l2[%0d]: rdv2=%b data=%h want 1/%h",
                     i - 1, rdv2, rd2, e);
         end
      end
      idle();
      cyc();
      checks++;
      if (readdatavalid !== 1'b0 || rdv2 !== 1'b1 || rd2 !== 32'hA5A50003) begin
         errors++;
         $display("FAIL b2b_tail: rdv=%b rdv2=%b data2=%h want 0/1/a5a50003",
                  readdatavalid, rdv2, rd2);
      end
      cyc();
      checks++;
      if (rdv2 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end: rdv2=%b want 0", rdv2);
      end
   endtask

   task automatic test_stall();
      chipselect = 1'b1;
      read       = 1'b1;
      address    = 12'h002;
      cyc();
      idle();
      clken = 1'b0;
      #1;
      checks++;
      if (readdatavalid !== 1'b0 || rdv2 !== 1'b0) begin
         errors++;
         $display("FAIL stall_mask: rdv=%b rdv2=%b want 0/0",
                  readdatavalid, rdv2);
      end
      for (int k = 0; k < 3; k++) begin
         cyc();
         checks++;
         if (readdatavalid !== 1'b0 || rdv2 !== 1'b0 ||
             rd2 !== 32'hA5A50003) begin
            errors++;
            $display("FAIL stall[%0d]: rdv=%b rdv2=%b data2=%h want 0/0/a5a50003",
                     k, readdatavalid, rdv2, rd2);
         end
      end
      clken = 1'b1;
      #1;
      checks++;
      if (readdatavalid !== 1'b1 || readdata !== 32'hA5A50002 ||
          rdv2 !== 1'b0) begin
         errors++;
         $display("FAIL stall_resume: rdv=%b data=%h rdv2=%b want 1/a5a50002/0",
                  readdatavalid, readdata, rdv2);
      end
      cyc();
      checks++;
      if (readdatavalid !== 1'b0 || rdv2 !== 1'b1 || rd2 !== 32'hA5A50002) begin
         errors++;
         $display("FAIL stall_l2: rdv=%b rdv2=%b data2=%h want 0/1/a5a50002",
                  readdatavalid, rdv2, rd2);
      end
      cyc();
   endtask

   task automatic test_oor();
      do_wr(12'hFA0, 32'hCAFEF00D, 4'b1111);
      do_rd(12'hFA0);
      checks++;
      if (readdatavalid !== 1'b1 || readdata !== 32'h0) begin
         errors++;
         $display("FAIL oor_read: rdv=%b data=%h want 1/00000000",
                  readdatavalid, readdata);
      end
      checks++;
      if (oor_err !== OOR_EXP || oor2 !== OOR_EXP) begin
         errors++;
         $display("FAIL oor_flag: got %b/%b want %b", oor_err, oor2, OOR_EXP);
      end
      do_rd(12'h000);
      checks++;
      if (readdata !== 32'hA5A50000 || rdv2 !== 1'b1 || rd2 !== 32'h0) begin
         errors++;
         $display("FAIL oor_nochg: data=%h rdv2=%b data2=%h want a5a50000/1/0",
                  readdata, rdv2, rd2);
      end
      cyc();
      checks++;
      if (rdv2 !== 1'b1 || rd2 !== 32'hA5A50000) begin
         errors++;
         $display("FAIL oor_alias: rdv2=%b data2=%h want 1/a5a50000",
                  rdv2, rd2);
      end
      repeat (3) cyc();
      checks++;
      if (oor_err !== OOR_EXP) begin
         errors++;
         $display("FAIL oor_sticky: got %b want %b", oor_err, OOR_EXP);
      end
   endtask

   task automatic test_rw_both();
      chipselect = 1'b1;
      read       = 1'b1;
      write      = 1'b1;
      address    = 12'h020;
      writedata  = 32'h55AA55AA;
      byteenable = 4'b1111;
      cyc();
      idle();
      checks++;
      if (readdatavalid !== 1'b0) begin
         errors++;
         $display("FAIL rw_norv: rdv=%b want 0", readdatavalid);
      end
      do_rd(12'h020);
      checks++;
      if (readdatavalid !== 1'b1 || readdata !== 32'h55AA55AA) begin
         errors++;
         $display("FAIL rw_write: rdv=%b data=%h want 1/55aa55aa",
                  readdatavalid, readdata);
      end
   endtask

   task automatic test_reset_pending();
      do_rd(12'h001);
      reset_n = 1'b0;
      cyc();
      checks++;
      if (readdatavalid !== 1'b0 || readdata !== 32'h0 ||
          rd2 !== 32'h0 || oor_err !== 1'b0) begin
         errors++;
         $display("FAIL rst_clr: rdv=%b data=%h data2=%h oor=%b want 0/0/0/0",
                  readdatavalid, readdata, rd2, oor_err);
      end
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rdv2 !== 1'b0) begin
            errors++;
            $display("FAIL rst_pend[%0d]: rdv2=%b want 0", k, rdv2);
         end
         cyc();
      end
   endtask

   task automatic test_reset_midclear();
      int n;
      repeat (100) cyc();
      checks++;
      if (waitrequest !== 1'b1) begin
         errors++;
         $display("FAIL midclr_busy: got %b want 1", waitrequest);
      end
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
      n = 0;
      while (waitrequest === 1'b1 && n < 5000) begin
         n++;
         cyc();
      end
      checks++;
      if (n != 4000) begin
         errors++;
         $display("FAIL midclr_len: got %0d clocks want 4000", n);
      end
      do_rd(12'h010);
      checks++;
      if (readdatavalid !== 1'b1 || readdata !== 32'h0) begin
         errors++;
         $display("FAIL midclr_zero: rdv=%b data=%h want 1/00000000",
                  readdatavalid, readdata);
      end
   endtask

   initial begin
      test_reset();
      test_clear();
      test_byteenable();
      test_back_to_back();
      test_stall();
      test_oor();
      test_rw_both();
      test_reset_pending();
      test_reset_midclear();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
